// File: rtl/router_pkt_reader.sv
// router_pkt_reader: consumer end of one router output port.
// Drains packets {hdr, payload[len], parity} from the port FIFO, forwards the
// payload bytes to a sink and checks the trailing XOR parity byte.
// Optional feature: define ROUTER_RD_ERRCNT_EN to build the saturating
// parity-error counter on err_count; otherwise err_count is tied to zero.
module router_pkt_reader #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LEN_W    = 6,
  parameter int unsigned READ_DLY = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              vld_out,
  input  logic [DATA_W-1:0] data_out,
  input  logic              soft_reset,
  input  logic              sink_ready,
  output logic              read_enb,
  output logic              byte_vld,
  output logic [DATA_W-1:0] byte_out,
  output logic              sop,
  output logic              eop,
  output logic [1:0]        pkt_addr,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_done,
  output logic              pkt_err,
  output logic              pkt_abort,
  output logic [7:0]        err_count
);

  localparam int unsigned REM_W = LEN_W + 1;
  localparam int unsigned DLY_W = 5;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(READ_DLY - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_HDR = 3'd1,
    HDR_W  = 3'd2,
    RD_PLD = 3'd3,
    RD_PAR = 3'd4,
    CHK    = 3'd5
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                rd_q;
  logic [DLY_W-1:0]    dly_cnt;
  logic [REM_W-1:0]    rem;
  logic [DATA_W-1:0]   par;
  logic                first_q;

  logic [LEN_W-1:0]    hdr_len_c;
  logic [1:0]          hdr_addr_c;
  logic                in_rd_c;
  logic                hdr_cap_c;
  logic                pld_smp_c;
  logic                chk_c;
  logic                abort_c;
  logic                par_ok_c;
  logic                dly_inc_c;

  assign hdr_len_c  = data_out[LEN_W+1:2];
  assign hdr_addr_c = data_out[1:0];

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; soft_reset outside IDLE always returns to IDLE
  always_comb begin
    state_nxt = state;
    if (state != IDLE && soft_reset) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (vld_out && !soft_reset && dly_cnt == DLY_LAST) state_nxt = RD_HDR;
        RD_HDR:  if (read_enb) state_nxt = HDR_W;
        HDR_W:   state_nxt = (hdr_len_c == '0) ? RD_PAR : RD_PLD;
        RD_PLD:  if (read_enb && rem == REM_W'(1)) state_nxt = RD_PAR;
        RD_PAR:  if (read_enb) state_nxt = CHK;
        CHK:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output / control decode: FIFO strobe and per-cycle datapath enables
  always_comb begin
    in_rd_c   = 1'b0;
    read_enb  = 1'b0;
    hdr_cap_c = 1'b0;
    pld_smp_c = 1'b0;
    chk_c     = 1'b0;
    abort_c   = 1'b0;
    par_ok_c  = 1'b0;
    dly_inc_c = 1'b0;

    in_rd_c   = (state == RD_HDR) || (state == RD_PLD) || (state == RD_PAR);
    read_enb  = in_rd_c && vld_out && sink_ready && !soft_reset;
    abort_c   = (state != IDLE) && soft_reset;
    // header byte lands in HDR_W; payload bytes land in RD_PLD or on RD_PAR entry
    hdr_cap_c = (state == HDR_W) && rd_q && !soft_reset;
    pld_smp_c = ((state == RD_PLD) || (state == RD_PAR)) && rd_q && !soft_reset;
    chk_c     = (state == CHK) && !soft_reset;
    par_ok_c  = (data_out == par);
    dly_inc_c = (state == IDLE) && vld_out && !soft_reset && (state_nxt == IDLE);
  end

  // Read pipeline, delay counter, remaining count and running parity
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_q    <= 1'b0;
      dly_cnt <= '0;
      rem     <= '0;
      par     <= '0;
      first_q <= 1'b0;
    end else begin
      rd_q <= read_enb;

      if (dly_inc_c) dly_cnt <= dly_cnt + DLY_W'(1);
      else           dly_cnt <= '0;

      if (hdr_cap_c)                        rem <= REM_W'(hdr_len_c);
      else if (state == RD_PLD && read_enb) rem <= rem - REM_W'(1);

      if (hdr_cap_c)      par <= data_out;
      else if (pld_smp_c) par <= par ^ data_out;

      if (hdr_cap_c)      first_q <= 1'b1;
      else if (pld_smp_c) first_q <= 1'b0;
    end
  end

  // Registered sink interface and packet status outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      byte_vld  <= 1'b0;
      byte_out  <= '0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      pkt_addr  <= '0;
      pkt_len   <= '0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      pkt_abort <= 1'b0;
    end else begin
      byte_vld <= pld_smp_c;
      sop      <= pld_smp_c && first_q;
      // rem already counts past the byte being delivered, so zero marks the last one
      eop      <= pld_smp_c && (rem == '0);
      if (pld_smp_c) byte_out <= data_out;

      if (hdr_cap_c) begin
        pkt_addr <= hdr_addr_c;
        pkt_len  <= hdr_len_c;
      end

      pkt_done  <= chk_c && par_ok_c;
      pkt_err   <= chk_c && !par_ok_c;
      pkt_abort <= abort_c;
    end
  end

`ifdef ROUTER_RD_ERRCNT_EN
  // Saturating parity-error counter, cleared only by resetn
  always_ff @(posedge clock) begin
    if (!resetn) begin
      err_count <= 8'h00;
    end else if (chk_c && !par_ok_c && err_count != 8'hFF) begin
      err_count <= err_count + 8'h01;
    end
  end
`else
  assign err_count = 8'h00;
`endif

endmodule
